// File: rtl/mem_stage.sv
// Y86-64 memory stage: M pipeline register plus a request/acknowledge data-memory
// access sequencer that freezes upstream stages while an access is in flight.
module mem_stage #(
    parameter int MEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        M_stall,
    input  logic        M_bubble,
    input  logic [1:0]  W_stat,
    input  logic [1:0]  e_stat,
    input  logic [3:0]  E_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] E_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic        m_busy,
    output logic [1:0]  m_stat,
    output logic [63:0] m_valM,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM
);

    localparam logic [1:0]  STAT_AOK = 2'b00;
    localparam logic [1:0]  STAT_ADR = 2'b10;
    localparam logic [3:0]  I_NOP    = 4'h1;
    localparam logic [3:0]  I_RMMOVQ = 4'h4;
    localparam logic [3:0]  I_MRMOVQ = 4'h5;
    localparam logic [3:0]  I_CALL   = 4'h8;
    localparam logic [3:0]  I_RET    = 4'h9;
    localparam logic [3:0]  I_PUSHQ  = 4'hA;
    localparam logic [3:0]  I_POPQ   = 4'hB;
    localparam logic [3:0]  REG_NONE = 4'hF;
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        is_read_s;
    logic        is_write_s;
    logic [63:0] acc_addr_s;
    logic        addr_ok_s;
    logic        adr_fault_s;
    logic        issue_s;
    logic        load_s;

    // Classify the incoming E-stage instruction and select its memory address
    always_comb begin
        is_read_s  = 1'b0;
        is_write_s = 1'b0;
        acc_addr_s = 64'h0;
        case (E_icode)
            I_MRMOVQ: begin
                is_read_s  = 1'b1;
                acc_addr_s = e_valE;
            end
            I_POPQ, I_RET: begin
                is_read_s  = 1'b1;
                acc_addr_s = E_valA;
            end
            I_RMMOVQ, I_PUSHQ, I_CALL: begin
                is_write_s = 1'b1;
                acc_addr_s = e_valE;
            end
            default: begin
                is_read_s  = 1'b0;
                is_write_s = 1'b0;
                acc_addr_s = 64'h0;
            end
        endcase
    end

    // Address legality, issue qualification and M load enable
    always_comb begin
        addr_ok_s   = (acc_addr_s <= ADDR_MAX);
        adr_fault_s = (is_read_s | is_write_s) & ~addr_ok_s & (e_stat == STAT_AOK);
        issue_s     = addr_ok_s & (e_stat == STAT_AOK) &
                      (is_read_s | (is_write_s & (W_stat == STAT_AOK)));
        load_s      = (state_r != ST_REQ) & ~M_stall;
    end

    assign m_busy = (state_r == ST_REQ);

    // Access sequencer next-state: a pending access blocks every load
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (dmem_ack) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (!load_s) begin
                    state_nxt_s = state_r;
                end else if (M_bubble) begin
                    state_nxt_s = ST_IDLE;
                end else if (issue_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state and registered request line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            dmem_req <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            dmem_req <= (state_nxt_s == ST_REQ);
        end
    end

    // Request attributes are captured at load and stay stable while requesting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= 64'h0;
            dmem_wdata <= 64'h0;
        end else if (load_s && !M_bubble && issue_s) begin
            dmem_we    <= is_write_s;
            dmem_addr  <= acc_addr_s;
            dmem_wdata <= E_valA;
        end
    end

    // M pipeline register; stat already reflects the address check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_icode <= I_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= 64'h0;
            M_valA  <= 64'h0;
            M_dstE  <= REG_NONE;
            M_dstM  <= REG_NONE;
            m_stat  <= STAT_AOK;
        end else if (load_s) begin
            if (M_bubble) begin
                M_icode <= I_NOP;
                M_Cnd   <= 1'b0;
                M_valE  <= 64'h0;
                M_valA  <= 64'h0;
                M_dstE  <= REG_NONE;
                M_dstM  <= REG_NONE;
                m_stat  <= STAT_AOK;
            end else begin
                M_icode <= E_icode;
                M_Cnd   <= e_Cnd;
                M_valE  <= e_valE;
                M_valA  <= E_valA;
                M_dstE  <= e_dstE;
                M_dstM  <= E_dstM;
                m_stat  <= adr_fault_s ? STAT_ADR : e_stat;
            end
        end
    end

    // Read data: cleared on every load, filled when a read is acknowledged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valM <= 64'h0;
        end else if (load_s) begin
            m_valM <= 64'h0;
        end else if ((state_r == ST_REQ) && dmem_ack && !dmem_we) begin
            m_valM <= dmem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scenario bench for mem_stage: expected memory requests are queued when an
// instruction is driven and compared when the DUT raises its request.
module tb_mem_stage;
    localparam int MEM_BYTES = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        M_stall, M_bubble, e_Cnd, dmem_ack;
    logic [1:0]  W_stat, e_stat;
    logic [3:0]  E_icode, e_dstE, E_dstM;
    logic [63:0] e_valE, E_valA, dmem_rdata;
    logic        dmem_req, dmem_we, m_busy, M_Cnd;
    logic [63:0] dmem_addr, dmem_wdata, m_valM, M_valE, M_valA;
    logic [1:0]  m_stat;
    logic [3:0]  M_icode, M_dstE, M_dstM;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    req_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    mem_stage #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .M_stall(M_stall), .M_bubble(M_bubble),
        .W_stat(W_stat), .e_stat(e_stat), .E_icode(E_icode), .e_Cnd(e_Cnd),
        .e_valE(e_valE), .E_valA(E_valA), .e_dstE(e_dstE), .E_dstM(E_dstM),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .m_busy(m_busy), .m_stat(m_stat), .m_valM(m_valM), .M_icode(M_icode),
        .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE),
        .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    // Present one instruction for exactly one load edge, then fall back to nop.
    task automatic load_instr(input logic [3:0] icode, input logic [63:0] vale,
                              input logic [63:0] vala, input logic [1:0] estat,
                              input logic [1:0] wstat);
        E_icode = icode; e_valE = vale; E_valA = vala; e_stat = estat; W_stat = wstat;
        e_Cnd = 1'b1; e_dstE = 4'hF; E_dstM = 4'h2;
        @(posedge clk); #1;
        E_icode = 4'h1; e_valE = 64'h0; E_valA = 64'h0; e_stat = 2'b00; W_stat = 2'b00;
        e_Cnd = 1'b0; e_dstE = 4'hF; E_dstM = 4'hF;
    endtask

    // Memory responder: acknowledges on the lat-th busy cycle, records the request.
    task automatic serve(input int lat, input logic [63:0] rdata, output int busy,
                         output logic seen, output req_t obs);
        busy = 0; seen = 1'b0; obs = '0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (!m_busy) break;
            busy++;
            if (dmem_req && !seen) begin
                seen = 1'b1;
                obs  = '{dmem_we, dmem_addr, dmem_we ? dmem_wdata : 64'h0};
            end
            if (busy == lat) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({dmem_req, m_busy, M_icode, M_Cnd, M_dstE, M_dstM, m_stat} !==
            {1'b0, 1'b0, 4'h1, 1'b0, 4'hF, 4'hF, 2'b00}) begin
            failures++;
            $display("FAIL reset_ctl: req=%0b busy=%0b icode=%h cnd=%0b dstE=%h dstM=%h stat=%0d, required 0 0 1 0 f f 0",
                     dmem_req, m_busy, M_icode, M_Cnd, M_dstE, M_dstM, m_stat);
        end
        checks++;
        if ({M_valE, M_valA, m_valM} !== 192'h0) begin
            failures++;
            $display("FAIL reset_data: valE=%h valA=%h valM=%h, required all zero", M_valE, M_valA, m_valM);
        end
    endtask

    task automatic test_read();
        int busy; logic seen; req_t obs, e;
        exp_q.push_back('{1'b0, 64'h100, 64'h0});
        load_instr(4'h5, 64'h100, 64'h0, 2'b00, 2'b00);
        serve(3, 64'hDEADBEEF, busy, seen, obs);
        checks++; e = exp_q.pop_front();
        if (!seen || obs !== e) begin
            failures++;
            $display("FAIL read_req: seen=%0b got %h, required %h", seen, obs, e);
        end
        checks++;
        if (busy != 3) begin failures++; $display("FAIL read_busy: %0d cycles, required 3", busy); end
        checks++;
        if ({m_valM, m_stat, M_icode, dmem_req} !== {64'hDEADBEEF, 2'b00, 4'h5, 1'b0}) begin
            failures++;
            $display("FAIL read_result: valM=%h stat=%0d icode=%h req=%0b, required deadbeef 0 5 0",
                     m_valM, m_stat, M_icode, dmem_req);
        end
        @(negedge clk);
        checks++;
        if ({M_icode, m_valM, m_busy} !== {4'h1, 64'h0, 1'b0}) begin
            failures++;
            $display("FAIL read_next_nop: icode=%h valM=%h busy=%0b, required 1 0 0", M_icode, m_valM, m_busy);
        end
    endtask

    task automatic test_write();
        int busy; logic seen; req_t obs, e;
        exp_q.push_back('{1'b1, 64'h1F8, 64'h55});
        load_instr(4'hA, 64'h1F8, 64'h55, 2'b00, 2'b00);
        serve(1, 64'h0, busy, seen, obs);
        checks++; e = exp_q.pop_front();
        if (!seen || obs !== e) begin
            failures++;
            $display("FAIL push_req: seen=%0b got %h, required %h", seen, obs, e);
        end
        checks++;
        if (busy != 1) begin failures++; $display("FAIL push_busy: %0d cycles, required 1", busy); end
        checks++;
        if ({m_stat, m_valM} !== {2'b00, 64'h0}) begin
            failures++;
            $display("FAIL push_result: stat=%0d valM=%h, required 0 0", m_stat, m_valM);
        end
    endtask

    task automatic test_addr_bounds();
        int busy; logic seen; req_t obs, e;
        load_instr(4'h4, 64'(MEM_BYTES - 4), 64'h77, 2'b00, 2'b00);
        serve(1, 64'h0, busy, seen, obs);
        checks++;
        if (seen || busy != 0 || m_stat !== 2'b10 || M_icode !== 4'h4) begin
            failures++;
            $display("FAIL bad_addr: seen=%0b busy=%0d stat=%0d icode=%h, required 0 0 2 4", seen, busy, m_stat, M_icode);
        end
        exp_q.push_back('{1'b1, 64'(MEM_BYTES - 8), 64'h99});
        load_instr(4'h4, 64'(MEM_BYTES - 8), 64'h99, 2'b00, 2'b00);
        serve(2, 64'h0, busy, seen, obs);
        checks++; e = exp_q.pop_front();
        if (!seen || obs !== e || busy != 2 || m_stat !== 2'b00) begin
            failures++;
            $display("FAIL top_addr: seen=%0b got %h busy=%0d stat=%0d, required %h 2 0", seen, obs, busy, m_stat, e);
        end
    endtask

    task automatic test_wstat_suppress();
        int busy; logic seen; req_t obs;
        load_instr(4'h4, 64'h40, 64'h66, 2'b00, 2'b01);
        serve(1, 64'h0, busy, seen, obs);
        checks++;
        if (seen || busy != 0) begin
            failures++;
            $display("FAIL wstat_write: seen=%0b busy=%0d, required no request", seen, busy);
        end
        checks++;
        if ({m_stat, M_icode, M_valE, M_valA} !== {2'b00, 4'h4, 64'h40, 64'h66}) begin
            failures++;
            $display("FAIL wstat_fields: stat=%0d icode=%h valE=%h valA=%h, required 0 4 40 66",
                     m_stat, M_icode, M_valE, M_valA);
        end
    endtask

    task automatic test_back_to_back();
        int busy; logic seen; req_t obs, e;
        exp_q.push_back('{1'b0, 64'h80, 64'h0});
        load_instr(4'hB, 64'h88, 64'h80, 2'b00, 2'b00);
        serve(2, 64'h1234, busy, seen, obs);
        checks++; e = exp_q.pop_front();
        if (!seen || obs !== e || m_valM !== 64'h1234) begin
            failures++;
            $display("FAIL pop_req: seen=%0b got %h valM=%h, required %h 1234", seen, obs, m_valM, e);
        end
        exp_q.push_back('{1'b1, 64'h78, 64'h400});
        load_instr(4'h8, 64'h78, 64'h400, 2'b00, 2'b00);
        serve(1, 64'hFFFF, busy, seen, obs);
        checks++; e = exp_q.pop_front();
        if (!seen || obs !== e || m_valM !== 64'h0 || M_icode !== 4'h8) begin
            failures++;
            $display("FAIL call_req: seen=%0b got %h valM=%h icode=%h, required %h 0 8", seen, obs, m_valM, M_icode, e);
        end
        exp_q.push_back('{1'b0, 64'h2000 - 64'h8, 64'h0});
        load_instr(4'h9, 64'h0, 64'h2000 - 64'h8, 2'b00, 2'b00);
        serve(1, 64'hABC, busy, seen, obs);
        checks++; e = exp_q.pop_front();
        if (!seen || obs !== e || m_valM !== 64'hABC) begin
            failures++;
            $display("FAIL ret_req: seen=%0b got %h valM=%h, required %h abc", seen, obs, m_valM, e);
        end
    endtask

    task automatic test_stall();
        load_instr(4'h3, 64'h10, 64'h0, 2'b00, 2'b00);
        checks++;
        if (M_icode !== 4'h3 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL irmovq_load: icode=%h busy=%0b, required 3 0", M_icode, m_busy);
        end
        M_stall = 1'b1;
        load_instr(4'h6, 64'h20, 64'h0, 2'b00, 2'b00);
        checks++;
        if (M_icode !== 4'h3 || M_valE !== 64'h10) begin
            failures++;
            $display("FAIL stall_hold: icode=%h valE=%h, required 3 10", M_icode, M_valE);
        end
        M_stall = 1'b0;
    endtask

    task automatic test_bubble_busy();
        int busy; logic seen; req_t obs, e;
        exp_q.push_back('{1'b0, 64'h300, 64'h0});
        load_instr(4'h5, 64'h300, 64'h0, 2'b00, 2'b00);
        M_bubble = 1'b1;
        serve(2, 64'hCAFE, busy, seen, obs);
        checks++; e = exp_q.pop_front();
        if (!seen || obs !== e || busy != 2) begin
            failures++;
            $display("FAIL bubble_req: seen=%0b got %h busy=%0d, required %h 2", seen, obs, busy, e);
        end
        checks++;
        if (M_icode !== 4'h5 || m_valM !== 64'hCAFE) begin
            failures++;
            $display("FAIL bubble_deferred: icode=%h valM=%h, required 5 cafe", M_icode, m_valM);
        end
        @(negedge clk);
        checks++;
        if ({M_icode, M_dstE, dmem_req, m_busy, m_valM} !== {4'h1, 4'hF, 1'b0, 1'b0, 64'h0}) begin
            failures++;
            $display("FAIL bubble_applied: icode=%h dstE=%h req=%0b busy=%0b valM=%h, required 1 f 0 0 0",
                     M_icode, M_dstE, dmem_req, m_busy, m_valM);
        end
        M_bubble = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        load_instr(4'h5, 64'h200, 64'h0, 2'b00, 2'b00);
        @(negedge clk);
        checks++;
        if (m_busy !== 1'b1 || dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL midreq_setup: busy=%0b req=%0b, required 1 1", m_busy, dmem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, m_busy, M_icode, M_dstE, M_dstM, m_stat} !== {1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 2'b00}) begin
            failures++;
            $display("FAIL midreq_reset: req=%0b busy=%0b icode=%h dstE=%h dstM=%h stat=%0d, required 0 0 1 f f 0",
                     dmem_req, m_busy, M_icode, M_dstE, M_dstM, m_stat);
        end
        @(negedge clk);
        rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 64'h5A5A;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({dmem_req, m_busy, m_valM} !== {1'b0, 1'b0, 64'h0}) begin
            failures++;
            $display("FAIL late_ack: req=%0b busy=%0b valM=%h, required 0 0 0", dmem_req, m_busy, m_valM);
        end
    endtask

    initial begin
        rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0; dmem_ack = 1'b0; dmem_rdata = 64'h0;
        W_stat = 2'b00; e_stat = 2'b00; E_icode = 4'h1; e_Cnd = 1'b0;
        e_valE = 64'h0; E_valA = 64'h0; e_dstE = 4'hF; E_dstM = 4'hF;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_read();
        test_write();
        test_addr_bounds();
        test_wstat_suppress();
        test_back_to_back();
        test_stall();
        test_bubble_busy();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the Y86-64 pipeline: holds the M pipeline register fed by the execute stage and performs the data-memory access for the instruction in M. Produces m_stat, m_valM and the forwarded M fields consumed by the write-back register and the forwarding logic. It talks to an external data memory over a request/acknowledge handshake and asserts m_busy to freeze upstream stages while an access is outstanding.

## Interface
- MEM_BYTES, 8192, data memory size in bytes; accesses are 8-byte words.
- clk  in  1  pipeline clock, all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- M_stall  in  1  hold M register (from pipeline control).
- M_bubble  in  1  load a bubble into M instead of E-stage values.
- W_stat  in  2  stat of instruction in W; a non-AOK value suppresses memory writes.
- e_stat  in  2  stat from execute.
- E_icode  in  4  icode from execute.
- e_Cnd  in  1  condition flag from execute.
- e_valE  in  64  ALU result.
- E_valA  in  64  valA from execute.
- e_dstE, E_dstM  in  4  destination registers.
- dmem_rdata  in  64  read data.
- dmem_ack  in  1  access complete; sampled only while dmem_req=1.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req=1.
- dmem_addr  out  64  byte address; valid while dmem_req=1.
- dmem_wdata  out  64  write data; valid while dmem_req=1.
- m_busy  out  1  access outstanding; upstream must hold.
- m_stat  out  2  stat after memory stage.
- m_valM  out  64  read data (0 for non-read instructions).
- M_icode  out  4, M_Cnd  out  1, M_valE  out  64, M_valA  out  64, M_dstE  out  4, M_dstM  out  4: registered M fields.

## Operation
- Stat encoding: 00 AOK, 01 HLT, 10 ADR, 11 INS.
- Register-load priority at each posedge: reset > m_busy (hold) > M_stall (hold) > M_bubble (bubble) > load from E.
- Bubble and reset value: icode 1 (nop), stat AOK, Cnd 0, valE/valA 0, dstE/dstM 0xF, m_valM 0.
- Access decode on the incoming instruction at load:
  - reads: mrmovq (5) addr=e_valE; popq (B) and ret (9) addr=E_valA.
  - writes data E_valA: rmmovq (4) and pushq (A) addr=e_valE; call (8) addr=e_valE.
  - All other icodes: no access.
- Address check: valid iff the unsigned addr <= MEM_BYTES-8. An invalid address issues no request; m_stat=ADR for that instruction. Otherwise m_stat=M stat.
- Write suppression: a write is not issued if e_stat≠AOK or W_stat≠AOK at the load edge. A read is not issued if e_stat≠AOK.
- FSM states:
  - IDLE: no access outstanding.
  - REQ: dmem_req=1, addr/we/wdata stable.
  - DONE: access finished, M holds result.
- FSM transitions:
  - Any load edge that issues an access → REQ. A load without an access → IDLE.
  - REQ with dmem_ack=1 → DONE, dmem_req←0. On reads, the valM register ← dmem_rdata.
  - DONE/IDLE remain until the next load.
- m_busy = (state==REQ), combinational from state.
- dmem_ack is ignored when dmem_req=0.

## Timing
- Reset (async, rst_n=0): state IDLE, dmem_req=0, m_busy=0, M fields at bubble values, m_stat AOK, m_valM 0. Any outstanding access is abandoned; a late ack after reset is ignored.
- Load edge N: dmem_req=1 from cycle N+1.
- Ack seen at edge N+k (k≥1): dmem_req=0 and m_valM valid from N+k. M loads a new instruction no earlier than edge N+k+1.
- m_busy is high from cycle N+1 through edge N+k. Minimum memory-instruction occupancy of M is 2 cycles.
- Non-memory instructions occupy M for 1 cycle and never assert m_busy.
- M_bubble or M_stall asserted while m_busy=1 has no effect until the access completes.

## Test plan
- Reset with rst_n=0 mid-REQ → dmem_req, m_busy drop immediately; M_icode=1, M_dstE=M_dstM=0xF, m_stat=00. A following ack is ignored.
- mrmovq with e_valE=0x100 and ack after 3 cycles returning 0xDEADBEEF → dmem_addr=0x100, dmem_we=0, m_busy high for 3 cycles, then m_valM=0xDEADBEEF, m_stat=00.
- pushq with e_valE=0x1F8, E_valA=0x55 and immediate ack → one request with dmem_we=1, wdata=0x55; m_busy high for exactly 1 cycle.
- rmmovq with e_valE=MEM_BYTES-4 → no dmem_req, m_stat=10, m_busy=0.
- rmmovq with W_stat=01 at load → no write issued, m_stat=00, M fields loaded normally.
- M_bubble during a busy read → bubble is not applied until the ack. Next cycle with M_bubble=1 → M_icode=1, no request.
